// File: rtl/bsg_vanilla_pkg.sv
// bsg_vanilla_pkg (local slice)
// Provides the remote request record shared by the core's remote-request path.
// Only the remote_req_s type is needed by remote_req_queue.
package bsg_vanilla_pkg;

  // One outbound remote memory request as issued by the core.
  typedef struct packed {
    logic        write_not_read;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
  } remote_req_s;

endpackage

// File: rtl/remote_req_queue_pkg.sv
// remote_req_queue_pkg
// Small helpers shared by the remote request queue files.
package remote_req_queue_pkg;

  // Circular-buffer pointer advance: wraps from els-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned els);
    return (ptr == els - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/remote_req_queue_credit.sv
// remote_credit_counter
// Saturating up/down counter tracking endpoint credits.
// Ports:
//   clk_i    - clock
//   reset_i  - asynchronous active-high reset, loads init_val_p
//   up_i     - one credit returned
//   down_i   - one credit consumed
//   count_o  - current credit count
module remote_credit_counter #(
  parameter int max_val_p  = 16,
  parameter int init_val_p = max_val_p,
  parameter int width_p    = $clog2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp  = width_p'(max_val_p);
  localparam logic [width_p-1:0] init_lp = width_p'(init_val_p);

  logic [width_p-1:0] count_d, count_q;

  // Simultaneous up and down cancel; otherwise saturate at both ends.
  always_comb begin
    count_d = count_q;
    if (up_i && !down_i && (count_q != max_lp)) begin
      count_d = count_q + width_p'(1);
    end else if (down_i && !up_i && (count_q != '0)) begin
      count_d = count_q - width_p'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_q <= init_lp;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (reset_i)
    !(up_i && !down_i && (count_q == max_lp)))
    else $error("credit counter overflow");

  a_no_underflow : assert property (@(posedge clk_i) disable iff (reset_i)
    !(down_i && !up_i && (count_q == '0)))
    else $error("credit counter underflow");

endmodule

// File: rtl/remote_req_queue.sv
// remote_req_queue
// Circular flop-array FIFO of remote requests plus the endpoint credit counter.
// Ports:
//   clk_i, reset_i      - clock, asynchronous active-high reset
//   core_req_v_i/_i     - request offered by the core
//   core_req_ready_o    - queue has room (not full)
//   remote_req_v_o/_o   - head entry toward the TX stage
//   remote_req_yumi_i   - TX stage consumed the head entry
//   out_sent_i          - packet left on the network (consumes a credit)
//   credit_v_i          - credit returned from the endpoint
//   out_credits_o       - available credits
//   empty_o             - queue holds no entries
//   fence_done_o        - queue empty and all credits home
module remote_req_queue
  import bsg_vanilla_pkg::*;
  import remote_req_queue_pkg::*;
#(
  parameter int els_p             = 4,
  // Deliberately meaningless default: every instance must set the credit limit.
  parameter int max_out_credits_p = 32'("inv"),
  localparam int credit_counter_width_lp = $clog2(max_out_credits_p + 1),
  localparam int count_width_lp          = $clog2(els_p + 1)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               core_req_v_i,
  input  remote_req_s                        core_req_i,
  output logic                               core_req_ready_o,
  output logic                               remote_req_v_o,
  output remote_req_s                        remote_req_o,
  input  logic                               remote_req_yumi_i,
  input  logic                               out_sent_i,
  input  logic                               credit_v_i,
  output logic [credit_counter_width_lp-1:0] out_credits_o,
  output logic                               empty_o,
  output logic                               fence_done_o
);

  localparam int ptr_width_lp = $clog2(els_p);
  localparam logic [count_width_lp-1:0] full_lp = count_width_lp'(els_p);

  logic [ptr_width_lp-1:0]   rd_ptr_d, rd_ptr_q;
  logic [ptr_width_lp-1:0]   wr_ptr_d, wr_ptr_q;
  logic [count_width_lp-1:0] count_d, count_q;
  remote_req_s               mem_q [els_p];
  logic                      enq, deq;

  assign core_req_ready_o = (count_q != full_lp);
  assign remote_req_v_o   = (count_q != '0);
  assign empty_o          = (count_q == '0);
  assign remote_req_o     = mem_q[rd_ptr_q];

  // Readiness depends only on the registered count, so a dequeue in the same
  // cycle never opens room for a write into a full queue.
  assign enq = core_req_v_i & core_req_ready_o;
  assign deq = remote_req_yumi_i & remote_req_v_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = ptr_width_lp'(wrap_inc(32'(wr_ptr_q), els_p));
    if (deq) rd_ptr_d = ptr_width_lp'(wrap_inc(32'(rd_ptr_q), els_p));
    case ({enq, deq})
      2'b10:   count_d = count_q + count_width_lp'(1);
      2'b01:   count_d = count_q - count_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is not reset; count gates its visibility.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= core_req_i;
  end

  remote_credit_counter #(
    .max_val_p  (max_out_credits_p),
    .init_val_p (max_out_credits_p),
    .width_p    (credit_counter_width_lp)
  ) credit_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (credit_v_i),
    .down_i  (out_sent_i),
    .count_o (out_credits_o)
  );

  // A drop (yumi without out_sent) is legal and leaves credits untouched.
  assign fence_done_o = empty_o &&
                        (out_credits_o == credit_counter_width_lp'(max_out_credits_p));

  a_yumi_when_valid : assert property (@(posedge clk_i) disable iff (reset_i)
    remote_req_yumi_i |-> remote_req_v_o)
    else $error("yumi asserted with no valid head entry");

endmodule
